multicycle_control_unit: RTL and testbench

Sequenced control unit for the multi-cycle successor of the 16-bit CPU. The ISA is unchanged: opcodes R-type/LW/SW/ADDI/BEQ/BNE/JMP, with funct ADD/SUB/SLL/AND. Instead of decoding one instruction per cycle, it steps FETCH/DECODE/EXEC/MEM/WB through one shared memory with a ready handshake. It adds wait-state tolerance, a memory-timeout trap, an illegal-opcode trap and a retired-instruction counter.

---
 rtl/multicycle_control_unit_pkg.sv | 60 ++++++
 rtl/multicycle_control_unit_if.sv | 53 +++++
 rtl/multicycle_control_unit_wait_timer.sv | 38 +++
 rtl/multicycle_control_unit.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_unit_pkg.sv
//------------------------------------------------------------------------------
// Module      : cpu_pkg
// Description : Shared ISA encodings, control-mux encodings and FSM states
//               for the multi-cycle 16-bit CPU control unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam logic [3:0] c_op_rtype = 4'b0000;
  localparam logic [3:0] c_op_lw    = 4'b0001;
  localparam logic [3:0] c_op_sw    = 4'b0010;
  localparam logic [3:0] c_op_addi  = 4'b0011;
  localparam logic [3:0] c_op_beq   = 4'b0100;
  localparam logic [3:0] c_op_bne   = 4'b0101;
  localparam logic [3:0] c_op_jmp   = 4'b0110;

  localparam logic [3:0] c_funct_add = 4'b0000;
  localparam logic [3:0] c_funct_sub = 4'b0001;
  localparam logic [3:0] c_funct_sll = 4'b0010;
  localparam logic [3:0] c_funct_and = 4'b0011;

  localparam logic [3:0] c_alu_add = 4'b0000;
  localparam logic [3:0] c_alu_sub = 4'b0001;
  localparam logic [3:0] c_alu_sll = 4'b0010;
  localparam logic [3:0] c_alu_and = 4'b0011;

  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_branch = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

  localparam logic [1:0] c_asb_rt  = 2'b00;
  localparam logic [1:0] c_asb_one = 2'b01;
  localparam logic [1:0] c_asb_imm = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  // Undefined funct codes pass through unchanged; the FSM traps on them.
  function automatic logic [3:0] funct_to_alu(input logic [3:0] funct);
    case (funct)
      c_funct_add: funct_to_alu = c_alu_add;
      c_funct_sub: funct_to_alu = c_alu_sub;
      c_funct_sll: funct_to_alu = c_alu_sll;
      c_funct_and: funct_to_alu = c_alu_and;
      default:     funct_to_alu = funct;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
//------------------------------------------------------------------------------
// Module      : multicycle_control_unit_if
// Description : Control/status bundle between the control unit (master) and
//               the datapath/memory side (slave).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 4,
  parameter int FUNCT_W  = 4,
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 16
);

  logic [OPCODE_W-1:0] opcode;
  logic [FUNCT_W-1:0]  Funct_field;
  logic                Zero;
  logic                mem_ready;
  logic                PC_Write;
  logic [1:0]          PC_Src;
  logic                IR_Write;
  logic                I_or_D;
  logic                Mem_Read;
  logic                Mem_Write;
  logic                Mem_to_Reg;
  logic                Reg_Write;
  logic                ALU_Src_A;
  logic [1:0]          ALU_Src_B;
  logic [ALU_OP_W-1:0] ALU_op;
  logic                Branch;
  logic                Jump;
  logic                Illegal_op;
  logic                Bus_Error;
  logic [CNT_W-1:0]    Instr_Retired;

  modport master (
    input  opcode, Funct_field, Zero, mem_ready,
    output PC_Write, PC_Src, IR_Write, I_or_D, Mem_Read, Mem_Write,
           Mem_to_Reg, Reg_Write, ALU_Src_A, ALU_Src_B, ALU_op,
           Branch, Jump, Illegal_op, Bus_Error, Instr_Retired
  );

  modport slave (
    output opcode, Funct_field, Zero, mem_ready,
    input  PC_Write, PC_Src, IR_Write, I_or_D, Mem_Read, Mem_Write,
           Mem_to_Reg, Reg_Write, ALU_Src_A, ALU_Src_B, ALU_op,
           Branch, Jump, Illegal_op, Bus_Error, Instr_Retired
  );

endinterface

`default_nettype wire

// File: rtl/multicycle_control_unit_wait_timer.sv
//------------------------------------------------------------------------------
// Module      : mcu_wait_timer
// Description : Counts consecutive memory wait cycles; flags the cycle that
//               would be the WAIT_MAX-th consecutive wait.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mcu_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_tick,
  input  wire logic i_clear,
  output logic      o_expired
);

  localparam int c_cnt_w = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_tick) begin
      r_count <= r_count + c_cnt_w'(1);
    end
  end

  // r_count holds the waits already seen, so this cycle is wait number r_count+1.
  assign o_expired = i_tick && (r_count == c_cnt_w'(WAIT_MAX - 1));

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
//------------------------------------------------------------------------------
// Module      : multicycle_control_unit
// Description : FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle CPU
//               with memory wait tolerance, traps and a retire counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control_unit
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int FUNCT_W  = 4,
  parameter int ALU_OP_W = 4,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  wire logic clk,
  input  wire logic rst_n,
  multicycle_control_unit_if.master bus
);

  state_t           r_state;
  state_t           w_next;
  logic             r_illegal_op;
  logic             r_bus_error;
  logic [CNT_W-1:0] r_retired;
  logic             w_tick;
  logic             w_clear;
  logic             w_expired;
  logic             w_retire;
  logic             w_set_ill;
  logic             w_set_bus;
  logic             w_is_lw;

  assign w_is_lw = (bus.opcode == OPCODE_W'(c_op_lw));

  mcu_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_tick    (w_tick),
    .i_clear   (w_clear),
    .o_expired (w_expired)
  );

  assign w_clear = ~w_tick | (w_next != r_state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_op <= 1'b0;
      r_bus_error  <= 1'b0;
      r_retired    <= '0;
    end else begin
      if (w_set_ill) r_illegal_op <= 1'b1;
      if (w_set_bus) r_bus_error  <= 1'b1;
      if (w_retire)  r_retired    <= r_retired + CNT_W'(1);
    end
  end

  assign bus.Illegal_op    = r_illegal_op;
  assign bus.Bus_Error     = r_bus_error;
  assign bus.Instr_Retired = r_retired;

  always_comb begin
    w_next         = r_state;
    w_tick         = 1'b0;
    w_retire       = 1'b0;
    w_set_ill      = 1'b0;
    w_set_bus      = 1'b0;
    bus.PC_Write   = 1'b0;
    bus.PC_Src     = c_pcsrc_alu;
    bus.IR_Write   = 1'b0;
    bus.I_or_D     = 1'b0;
    bus.Mem_Read   = 1'b0;
    bus.Mem_Write  = 1'b0;
    bus.Mem_to_Reg = 1'b0;
    bus.Reg_Write  = 1'b0;
    bus.ALU_Src_A  = 1'b0;
    bus.ALU_Src_B  = c_asb_rt;
    bus.ALU_op     = ALU_OP_W'(c_alu_add);
    bus.Branch     = 1'b0;
    bus.Jump       = 1'b0;

    case (r_state)
      S_IDLE: w_next = S_FETCH;

      S_FETCH: begin
        bus.Mem_Read  = 1'b1;
        bus.ALU_Src_B = c_asb_one;
        bus.IR_Write  = bus.mem_ready;
        bus.PC_Write  = bus.mem_ready;
        w_tick        = ~bus.mem_ready;
        if (bus.mem_ready) begin
          w_next = S_DECODE;
        end else if (w_expired) begin
          w_next    = S_TRAP;
          w_set_bus = 1'b1;
        end
      end

      S_DECODE: begin
        bus.ALU_Src_B = c_asb_imm;
        if (bus.opcode > OPCODE_W'(c_op_jmp)) begin
          w_next    = S_TRAP;
          w_set_ill = 1'b1;
        end else begin
          w_next = S_EXEC;
        end
      end

      S_EXEC: begin
        case (bus.opcode)
          OPCODE_W'(c_op_rtype): begin
            bus.ALU_Src_A = 1'b1;
            bus.ALU_op    = ALU_OP_W'(funct_to_alu(4'(bus.Funct_field)));
            if (bus.Funct_field > FUNCT_W'(c_funct_and)) begin
              w_next    = S_TRAP;
              w_set_ill = 1'b1;
            end else begin
              w_next = S_WB;
            end
          end
          OPCODE_W'(c_op_lw), OPCODE_W'(c_op_sw), OPCODE_W'(c_op_addi): begin
            bus.ALU_Src_A = 1'b1;
            bus.ALU_Src_B = c_asb_imm;
            w_next = (bus.opcode == OPCODE_W'(c_op_addi)) ? S_WB : S_MEM;
          end
          OPCODE_W'(c_op_beq), OPCODE_W'(c_op_bne): begin
            bus.ALU_Src_A = 1'b1;
            bus.ALU_op    = ALU_OP_W'(c_alu_sub);
            bus.Branch    = 1'b1;
            bus.PC_Src    = c_pcsrc_branch;
            bus.PC_Write  = (bus.opcode == OPCODE_W'(c_op_beq)) ? bus.Zero : ~bus.Zero;
            w_next        = S_FETCH;
            w_retire      = 1'b1;
          end
          OPCODE_W'(c_op_jmp): begin
            bus.Jump     = 1'b1;
            bus.PC_Src   = c_pcsrc_jump;
            bus.PC_Write = 1'b1;
            w_next       = S_FETCH;
            w_retire     = 1'b1;
          end
          default: begin
            w_next    = S_TRAP;
            w_set_ill = 1'b1;
          end
        endcase
      end

      S_MEM: begin
        bus.I_or_D    = 1'b1;
        bus.Mem_Read  = w_is_lw;
        bus.Mem_Write = ~w_is_lw;
        w_tick        = ~bus.mem_ready;
        if (bus.mem_ready) begin
          w_next   = w_is_lw ? S_WB : S_FETCH;
          w_retire = ~w_is_lw;
        end else if (w_expired) begin
          w_next    = S_TRAP;
          w_set_bus = 1'b1;
        end
      end

      S_WB: begin
        bus.Reg_Write  = 1'b1;
        bus.Mem_to_Reg = w_is_lw;
        w_next         = S_FETCH;
        w_retire       = 1'b1;
      end

      S_TRAP: w_next = S_TRAP;

      default: w_next = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_multicycle_control_unit
// Description : Directed self-checking bench for multicycle_control_unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control_unit;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  multicycle_control_unit_if #(
    .OPCODE_W (4), .FUNCT_W (4), .ALU_OP_W (4), .CNT_W (16)
  ) bus ();

  multicycle_control_unit #(
    .OPCODE_W (4), .FUNCT_W (4), .ALU_OP_W (4), .WAIT_MAX (15), .CNT_W (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {PC_Write, PC_Src, IR_Write, I_or_D, Mem_Read, Mem_Write, Mem_to_Reg,
  //  Reg_Write, ALU_Src_A, ALU_Src_B, ALU_op, Branch, Jump}
  function automatic logic [17:0] cv(input logic pcw, input logic [1:0] src, input logic irw,
                                     input logic iord, input logic mr, input logic mw,
                                     input logic m2r, input logic rw, input logic asa,
                                     input logic [1:0] asb, input logic [3:0] op,
                                     input logic br, input logic j);
    return {pcw, src, irw, iord, mr, mw, m2r, rw, asa, asb, op, br, j};
  endfunction

  function automatic logic [17:0] act();
    return {bus.PC_Write, bus.PC_Src, bus.IR_Write, bus.I_or_D, bus.Mem_Read, bus.Mem_Write,
            bus.Mem_to_Reg, bus.Reg_Write, bus.ALU_Src_A, bus.ALU_Src_B, bus.ALU_op,
            bus.Branch, bus.Jump};
  endfunction

  task automatic ctl(input string tag, input logic [17:0] exp);
    check(tag, {14'b0, act()}, {14'b0, exp});
  endtask

  task automatic st(input string tag, input state_t exp);
    check(tag, 32'(dut.r_state), 32'(exp));
  endtask

  // Advance one clock and drive this cycle's inputs, then let outputs settle.
  task automatic step(input logic [3:0] op, input logic [3:0] fn, input logic mr, input logic z);
    @(posedge clk);
    #1;
    bus.opcode      = op;
    bus.Funct_field = fn;
    bus.mem_ready   = mr;
    bus.Zero        = z;
    #1;
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    ctl("rst_outputs", 18'h0);
    check("rst_illegal", {31'b0, bus.Illegal_op}, 32'd0);
    check("rst_bus_err", {31'b0, bus.Bus_Error}, 32'd0);
    check("rst_retired", {16'b0, bus.Instr_Retired}, 32'd0);
    st("rst_state", S_IDLE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    ctl("idle_outputs", 18'h0);
    st("idle_state", S_IDLE);
  endtask

  logic [17:0] e_fetch, e_fwait, e_dec, e_exi, e_memr, e_memw, e_wbl, e_wb, e_jmp;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.opcode      = 4'h0;
    bus.Funct_field = 4'h0;
    bus.mem_ready   = 1'b1;
    bus.Zero        = 1'b0;

    e_fetch = cv(1, 2'b00, 1, 0, 1, 0, 0, 0, 0, 2'b01, 4'h0, 0, 0);
    e_fwait = cv(0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b01, 4'h0, 0, 0);
    e_dec   = cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b10, 4'h0, 0, 0);
    e_exi   = cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'h0, 0, 0);
    e_memr  = cv(0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0);
    e_memw  = cv(0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 2'b00, 4'h0, 0, 0);
    e_wbl   = cv(0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 2'b00, 4'h0, 0, 0);
    e_wb    = cv(0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 2'b00, 4'h0, 0, 0);
    e_jmp   = cv(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, 1);

    reset_pulse();

    // ADD then AND
    step(4'h0, 4'h0, 1, 0); ctl("add_fetch", e_fetch); st("add_fetch_st", S_FETCH);
    step(4'h0, 4'h0, 1, 0); ctl("add_decode", e_dec);
    step(4'h0, 4'h0, 1, 0); ctl("add_exec", cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'h0, 0, 0));
    step(4'h0, 4'h0, 1, 0); ctl("add_wb", e_wb);
    step(4'h0, 4'h3, 1, 0); ctl("and_fetch", e_fetch);
    check("add_retired", {16'b0, bus.Instr_Retired}, 32'd1);
    step(4'h0, 4'h3, 1, 0); ctl("and_decode", e_dec);
    step(4'h0, 4'h3, 1, 0); ctl("and_exec", cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'h3, 0, 0));
    step(4'h0, 4'h3, 1, 0); ctl("and_wb", e_wb);

    // LW with three wait cycles in MEM
    step(4'h1, 4'h0, 1, 0); ctl("lw_fetch", e_fetch);
    check("and_retired", {16'b0, bus.Instr_Retired}, 32'd2);
    step(4'h1, 4'h0, 1, 0); ctl("lw_decode", e_dec);
    step(4'h1, 4'h0, 1, 0); ctl("lw_exec", e_exi);
    for (int i = 0; i < 3; i++) begin
      step(4'h1, 4'h0, 0, 0); ctl("lw_mem_wait", e_memr); st("lw_mem_wait_st", S_MEM);
    end
    step(4'h1, 4'h0, 1, 0); ctl("lw_mem_done", e_memr);
    step(4'h1, 4'h0, 1, 0); ctl("lw_wb", e_wbl);

    // SW
    step(4'h2, 4'h0, 1, 0); ctl("sw_fetch", e_fetch);
    check("lw_retired", {16'b0, bus.Instr_Retired}, 32'd3);
    step(4'h2, 4'h0, 1, 0); ctl("sw_decode", e_dec);
    step(4'h2, 4'h0, 1, 0); ctl("sw_exec", e_exi);
    step(4'h2, 4'h0, 1, 0); ctl("sw_mem", e_memw);

    // ADDI
    step(4'h3, 4'h0, 1, 0); ctl("addi_fetch", e_fetch);
    check("sw_retired", {16'b0, bus.Instr_Retired}, 32'd4);
    step(4'h3, 4'h0, 1, 0); ctl("addi_decode", e_dec);
    step(4'h3, 4'h0, 1, 0); ctl("addi_exec", e_exi);
    step(4'h3, 4'h0, 1, 0); ctl("addi_wb", e_wb);

    // BEQ Zero=1, BNE Zero=1, BNE Zero=0
    step(4'h4, 4'h0, 1, 1); ctl("beq_fetch", e_fetch);
    check("addi_retired", {16'b0, bus.Instr_Retired}, 32'd5);
    step(4'h4, 4'h0, 1, 1); ctl("beq_decode", e_dec);
    step(4'h4, 4'h0, 1, 1); ctl("beq_exec_z1", cv(1, 2'b01, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'h1, 1, 0));
    step(4'h5, 4'h0, 1, 1); ctl("bne_fetch", e_fetch);
    check("beq_retired", {16'b0, bus.Instr_Retired}, 32'd6);
    step(4'h5, 4'h0, 1, 1); ctl("bne_decode", e_dec);
    step(4'h5, 4'h0, 1, 1); ctl("bne_exec_z1", cv(0, 2'b01, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'h1, 1, 0));
    step(4'h5, 4'h0, 1, 0); ctl("bne2_fetch", e_fetch);
    check("bne_retired", {16'b0, bus.Instr_Retired}, 32'd7);
    step(4'h5, 4'h0, 1, 0); ctl("bne2_decode", e_dec);
    step(4'h5, 4'h0, 1, 0); ctl("bne_exec_z0", cv(1, 2'b01, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'h1, 1, 0));

    // JMP
    step(4'h6, 4'h0, 1, 0); ctl("jmp_fetch", e_fetch);
    step(4'h6, 4'h0, 1, 0); ctl("jmp_decode", e_dec);
    step(4'h6, 4'h0, 1, 0); ctl("jmp_exec", e_jmp);

    // Illegal opcode 1010
    step(4'hA, 4'h0, 1, 0); ctl("ill_fetch", e_fetch);
    check("jmp_retired", {16'b0, bus.Instr_Retired}, 32'd9);
    step(4'hA, 4'h0, 1, 0); ctl("ill_decode", e_dec);
    step(4'hA, 4'h0, 1, 0); ctl("ill_trap_out", 18'h0); st("ill_trap_st", S_TRAP);
    check("ill_flag", {31'b0, bus.Illegal_op}, 32'd1);
    step(4'h0, 4'h0, 1, 0); ctl("ill_trap_hold", 18'h0); st("ill_trap_hold_st", S_TRAP);
    check("ill_no_retire", {16'b0, bus.Instr_Retired}, 32'd9);
    reset_pulse();

    // Illegal funct 0111
    step(4'h0, 4'h7, 1, 0); ctl("fn7_fetch", e_fetch);
    step(4'h0, 4'h7, 1, 0); ctl("fn7_decode", e_dec);
    step(4'h0, 4'h7, 1, 0); ctl("fn7_exec", cv(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'h7, 0, 0));
    step(4'h0, 4'h7, 1, 0); ctl("fn7_trap_out", 18'h0); st("fn7_trap_st", S_TRAP);
    check("fn7_flag", {31'b0, bus.Illegal_op}, 32'd1);
    check("fn7_no_retire", {16'b0, bus.Instr_Retired}, 32'd0);
    reset_pulse();

    // SW aborted by reset while waiting in MEM
    step(4'h2, 4'h0, 1, 0); ctl("abort_fetch", e_fetch);
    step(4'h2, 4'h0, 1, 0);
    step(4'h2, 4'h0, 1, 0);
    step(4'h2, 4'h0, 0, 0); ctl("abort_mem", e_memw);
    reset_pulse();

    // FETCH timeout after 15 waits
    for (int k = 1; k <= 15; k++) begin
      step(4'h0, 4'h0, 0, 0); ctl("tmo_wait", e_fwait); st("tmo_wait_st", S_FETCH);
    end
    check("tmo_pre_flag", {31'b0, bus.Bus_Error}, 32'd0);
    step(4'h0, 4'h0, 0, 0); ctl("tmo_trap_out", 18'h0); st("tmo_trap_st", S_TRAP);
    check("tmo_flag", {31'b0, bus.Bus_Error}, 32'd1);
    check("tmo_ill_clear", {31'b0, bus.Illegal_op}, 32'd0);
    reset_pulse();

    // Ready arriving on the 15th wait cycle completes normally
    for (int k = 1; k <= 14; k++) begin
      step(4'h0, 4'h0, 0, 0); ctl("edge_wait", e_fwait);
    end
    step(4'h0, 4'h0, 1, 0); ctl("edge_ready", e_fetch);
    step(4'h0, 4'h0, 1, 0); ctl("edge_decode", e_dec); st("edge_decode_st", S_DECODE);
    check("edge_no_err", {31'b0, bus.Bus_Error}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
